freqgen: RTL and testbench
==========================

# freqgen

BCD-programmed square-wave test-signal generator: the source-side counterpart of `freqcnt`. It takes the same four BCD digits and range bit that `freqcnt` displays and produces `sigout` at that frequency, derived from `sysclk` by a fractional accumulator. The average frequency is exact; edge jitter is at most one `sysclk` period. It feeds `freqcnt`'s measured input in self-test and closed-loop benches.

## Interface
- `F_SYS`, 50_000_000, `sysclk` frequency in Hz; must be even
- `ACC_W`, 26, accumulator/increment width; must satisfy 2^ACC_W > F_SYS/2 + 99990
- `sysclk`  in  1  system clock; every register is on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `load`  in  1  single-cycle request to program a new frequency
- `range`  in  1  0: digits are Hz; 1: digits ×10 Hz
- `freq0`..`freq3`  in  4 each  BCD digits; `freq0` least significant
- `sigout`  out  1  generated square wave
- `busy`  out  1  conversion in progress
- `err`  out  1  last load was rejected (a digit > 9)
- `active`  out  1  programmed frequency is non-zero
- `rangedisp`  out  1  range of the currently applied setting

## Operation
- Reset: `sigout`=0, `busy`=0, `err`=0, `active`=0, `rangedisp`=0, `inc`=0, `acc`=0, FSM=IDLE. Reset overrides everything, including a conversion in progress.
- IDLE, `load`=1:
  - If any digit > 9: set `err`=1 and stay in IDLE. The current setting is untouched and `busy` is never raised.
  - Otherwise: latch the digits and `range`, clear `err`, go to CONV.
- CONV: four cycles, most significant digit first (`freq3`, `freq2`, `freq1`, `freq0`). Each cycle: `bin` = `bin`·10 + digit, with `bin` starting at 0.
- SCALE: one cycle, always taken. If the latched range is 1, `bin` = `bin`·10; otherwise `bin` is unchanged.
- APPLY: one cycle, then back to IDLE. In this cycle:
  - `inc` ← `bin`, `acc` ← 0, `sigout` ← 0
  - `rangedisp` ← latched range, `active` ← (`bin` ≠ 0)
- `load` while `busy`=1 is ignored. It does not set `err`.
- Accumulator, every cycle except APPLY: `sum` = `acc` + `inc`, with HALF = F_SYS/2.
  - If `sum` ≥ HALF: `acc` ← `sum` − HALF and toggle `sigout`.
  - Otherwise: `acc` ← `sum`.
- While a new setting is converting, the previous frequency keeps running.
- `inc`=0: `sigout` holds 0.
- Maximum output is 99990 Hz. Arithmetic is unsigned. `bin` is at most 17 bits and is zero-extended to ACC_W.

## Timing
- `load` sampled at edge k (accepted): `busy`=1 after edges k through k+5, and `busy`=0 after edge k+6.
  - CONV occupies edges k+1..k+4, SCALE k+5, APPLY k+6.
  - The new `inc`, `rangedisp` and `active` are visible after edge k+6.
- First toggle of a new setting lands at edge k+6+N, with N = ceil(HALF/f). Later toggle intervals are floor(HALF/f) or ceil(HALF/f) cycles.
- Rejected load: `err`=1 after edge k; the outputs are otherwise unaffected.
- Throughput: one accepted load per 7 cycles.

## Structure
- `freqgen_pkg`:
  - state enum {IDLE, CONV, SCALE, APPLY}
  - default `F_SYS`, derived HALF, `ACC_W`
  - BCD digit-valid function
- Sub-module `bcd4_to_bin`: sequential converter covering CONV and SCALE, with start/done. The top level holds the FSM control, the accumulator and the outputs.

## Test plan
- Reset, then load 1,2,5,0 with range=1 (12500 Hz): `busy` high for exactly 6 cycles, `rangedisp`=1, `active`=1. First toggle 2000 cycles after APPLY; every interval 2000 cycles; period 4000 cycles = 80 µs.
- Load 9,9,9,9 with range=1 (99990 Hz): first 40 toggle intervals are 251, then 250 (38 times), then 251, totalling 10002 cycles.
- Load with `freq2`=4'hA while running 12500 Hz: `err`=1, `busy` stays 0, 4000-cycle period continues. Next valid load clears `err`.
- Load 0,0,0,0: `sigout`=0 and `active`=0 for 10000 cycles.
- Pulse `load` with new digits on the 3rd `busy` cycle: ignored. The setting from the first load is applied and `err`=0.
- Assert `rst` on the 4th `busy` cycle: after the next edge all outputs are at reset values. `sigout` stays 0 until a new load.

Source files
------------

// File: rtl/freqgen_pkg.sv
// Shared types, defaults and helpers for the freqgen BCD-programmed square-wave generator.
package freqgen_pkg;

  localparam int unsigned F_SYS_DEFAULT = 32'd50_000_000;
  localparam int unsigned HALF_DEFAULT  = F_SYS_DEFAULT / 32'd2;
  localparam int unsigned ACC_W_DEFAULT = 32'd26;
  localparam int unsigned BIN_W         = 32'd17;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SCALE = 2'd2,
    APPLY = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_DIGIT = 2'd1,
    CV_SCALE = 2'd2
  } conv_phase_e;

  function automatic logic bcd_digit_valid(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/freqgen_bcd4_to_bin.sv
// Sequential four-digit BCD to binary converter: one digit per cycle, MSD first,
// then an optional x10 range scale. `done` pulses the cycle after scaling.
module bcd4_to_bin
  import freqgen_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      digits,
  input  logic             range_in,
  output logic [BIN_W-1:0] bin,
  output logic             range_lat,
  output logic             last_digit,
  output logic             done
);

  localparam logic [BIN_W-1:0] TEN = BIN_W'(4'd10);

  conv_phase_e      phase_q, phase_d;
  logic [1:0]       step_q, step_d;
  logic [15:0]      digits_q, digits_d;
  logic             range_q, range_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             done_q, done_d;

  always_comb begin
    phase_d  = phase_q;
    step_d   = step_q;
    digits_d = digits_q;
    range_d  = range_q;
    bin_d    = bin_q;
    done_d   = 1'b0;
    case (phase_q)
      CV_IDLE: begin
        if (start) begin
          digits_d = digits;
          range_d  = range_in;
          bin_d    = '0;
          step_d   = 2'd0;
          phase_d  = CV_DIGIT;
        end else begin
          phase_d  = CV_IDLE;
        end
      end
      CV_DIGIT: begin
        // Digits are shifted out from the top so the MSD is always in [15:12].
        bin_d    = (bin_q * TEN) + {{(BIN_W-4){1'b0}}, digits_q[15:12]};
        digits_d = {digits_q[11:0], 4'd0};
        step_d   = step_q + 2'd1;
        if (step_q == 2'd3) begin
          phase_d = CV_SCALE;
        end else begin
          phase_d = CV_DIGIT;
        end
      end
      CV_SCALE: begin
        if (range_q) begin
          bin_d = bin_q * TEN;
        end else begin
          bin_d = bin_q;
        end
        done_d  = 1'b1;
        phase_d = CV_IDLE;
      end
      default: begin
        phase_d = CV_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= CV_IDLE;
      step_q   <= 2'd0;
      digits_q <= 16'd0;
      range_q  <= 1'b0;
      bin_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      step_q   <= step_d;
      digits_q <= digits_d;
      range_q  <= range_d;
      bin_q    <= bin_d;
      done_q   <= done_d;
    end
  end

  assign bin        = bin_q;
  assign range_lat  = range_q;
  assign last_digit = (phase_q == CV_DIGIT) && (step_q == 2'd3);
  assign done       = done_q;

endmodule

// File: rtl/freqgen.sv
// BCD-programmed square-wave generator: a load FSM feeds a fractional accumulator
// that toggles sigout each time the running sum crosses F_SYS/2.
module freqgen
  import freqgen_pkg::*;
#(
  parameter int unsigned F_SYS = F_SYS_DEFAULT,
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       load,
  input  logic       range,
  input  logic [3:0] freq0,
  input  logic [3:0] freq1,
  input  logic [3:0] freq2,
  input  logic [3:0] freq3,
  output logic       sigout,
  output logic       busy,
  output logic       err,
  output logic       active,
  output logic       rangedisp
);

  localparam logic [ACC_W-1:0] HALF = ACC_W'(F_SYS / 32'd2);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             active_q, active_d;
  logic             rangedisp_q, rangedisp_d;
  logic             sigout_q, sigout_d;
  logic [ACC_W-1:0] inc_q, inc_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sum_s;
  logic             digits_ok_s;
  logic             start_s;
  logic [BIN_W-1:0] conv_bin_s;
  logic             conv_range_s;
  logic             conv_last_s;
  logic             conv_done_s;

  assign digits_ok_s = bcd_digit_valid(freq0) && bcd_digit_valid(freq1) &&
                       bcd_digit_valid(freq2) && bcd_digit_valid(freq3);

  bcd4_to_bin u_conv (
    .clk        (sysclk),
    .rst        (rst),
    .start      (start_s),
    .digits     ({freq3, freq2, freq1, freq0}),
    .range_in   (range),
    .bin        (conv_bin_s),
    .range_lat  (conv_range_s),
    .last_digit (conv_last_s),
    .done       (conv_done_s)
  );

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    err_d       = err_q;
    active_d    = active_q;
    rangedisp_d = rangedisp_q;
    inc_d       = inc_q;
    start_s     = 1'b0;
    // The old setting keeps running while a new one converts; APPLY overrides below.
    sum_s = acc_q + inc_q;
    if (sum_s >= HALF) begin
      acc_d    = sum_s - HALF;
      sigout_d = ~sigout_q;
    end else begin
      acc_d    = sum_s;
      sigout_d = sigout_q;
    end
    case (state_q)
      IDLE: begin
        if (load && digits_ok_s) begin
          start_s = 1'b1;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = CONV;
        end else if (load) begin
          err_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (conv_last_s) begin
          state_d = SCALE;
        end else begin
          state_d = CONV;
        end
      end
      SCALE: begin
        state_d = APPLY;
      end
      APPLY: begin
        if (conv_done_s) begin
          inc_d       = {{(ACC_W-BIN_W){1'b0}}, conv_bin_s};
          acc_d       = '0;
          sigout_d    = 1'b0;
          rangedisp_d = conv_range_s;
          active_d    = (conv_bin_s != '0);
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d     = APPLY;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      active_q    <= 1'b0;
      rangedisp_q <= 1'b0;
      sigout_q    <= 1'b0;
      inc_q       <= '0;
      acc_q       <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      active_q    <= active_d;
      rangedisp_q <= rangedisp_d;
      sigout_q    <= sigout_d;
      inc_q       <= inc_d;
      acc_q       <= acc_d;
    end
  end

  assign sigout    = sigout_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign active    = active_q;
  assign rangedisp = rangedisp_q;

endmodule

// File: tb/tb_freqgen.sv
// Directed bench for freqgen: a table of loads with hand-computed first-toggle
// delays, plus sequences for jitter pattern, rejected loads, ignored loads and reset.
module tb_freqgen;

  logic       sysclk = 1'b0;
  logic       rst;
  logic       load;
  logic       range;
  logic [3:0] freq0, freq1, freq2, freq3;
  logic       sigout, busy, err, active, rangedisp;

  int n_cmp = 0;
  int n_bad = 0;

  freqgen dut (
    .sysclk    (sysclk),
    .rst       (rst),
    .load      (load),
    .range     (range),
    .freq0     (freq0),
    .freq1     (freq1),
    .freq2     (freq2),
    .freq3     (freq3),
    .sigout    (sigout),
    .busy      (busy),
    .err       (err),
    .active    (active),
    .rangedisp (rangedisp)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [3:0] d3, d2, d1, d0;
    logic       rng;
    logic       exp_active;
    int         exp_first;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives load for exactly one edge; returns 1 ns after that edge.
  task automatic do_load(input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1, input logic [3:0] d0, input logic rng);
    @(negedge sysclk);
    freq3 = d3; freq2 = d2; freq1 = d1; freq0 = d0; range = rng;
    load = 1'b1;
    @(posedge sysclk); #1;
    load = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = busy ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge sysclk); #1;
      if (busy) n++;
      else break;
    end
  endtask

  task automatic wait_toggle(input int limit, output int cyc);
    logic s0;
    s0  = sigout;
    cyc = 0;
    while (sigout == s0 && cyc < limit) begin
      @(posedge sysclk); #1;
      cyc++;
    end
  endtask

  initial begin
    int nb, t, total, bad, expi;
    rst = 1'b1; load = 1'b0; range = 1'b0;
    freq0 = 4'd0; freq1 = 4'd0; freq2 = 4'd0; freq3 = 4'd0;
    repeat (3) @(posedge sysclk);
    #1;
    chk("reset sigout", int'(sigout), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset err", int'(err), 0);
    chk("reset active", int'(active), 0);
    chk("reset rangedisp", int'(rangedisp), 0);
    rst = 1'b0;

    // HALF = 25_000_000; first toggle after ceil(HALF/f) cycles.
    vecs[0] = '{4'd1, 4'd2, 4'd5, 4'd0, 1'b1, 1'b1, 2000};
    vecs[1] = '{4'd4, 4'd3, 4'd2, 4'd1, 1'b1, 1'b1, 579};
    vecs[2] = '{4'd9, 4'd9, 4'd9, 4'd9, 1'b0, 1'b1, 2501};
    vecs[3] = '{4'd5, 4'd0, 4'd0, 4'd0, 1'b1, 1'b1, 500};
    vecs[4] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 0};

    for (int i = 0; i < 5; i++) begin
      do_load(vecs[i].d3, vecs[i].d2, vecs[i].d1, vecs[i].d0, vecs[i].rng);
      count_busy(nb);
      chk($sformatf("v%0d busy_len", i), nb, 6);
      chk($sformatf("v%0d rangedisp", i), int'(rangedisp), int'(vecs[i].rng));
      chk($sformatf("v%0d active", i), int'(active), int'(vecs[i].exp_active));
      chk($sformatf("v%0d err", i), int'(err), 0);
      chk($sformatf("v%0d sigout_at_apply", i), int'(sigout), 0);
      if (vecs[i].exp_first > 0) begin
        wait_toggle(vecs[i].exp_first + 50, t);
        chk($sformatf("v%0d first_toggle", i), t, vecs[i].exp_first);
      end else begin
        bad = 0;
        repeat (10000) begin
          @(posedge sysclk); #1;
          if (sigout !== 1'b0 || active !== 1'b0) bad++;
        end
        chk($sformatf("v%0d zero_hold", i), bad, 0);
      end
    end

    // 99990 Hz: 251, 38 x 250, 251 -> 10002 cycles over 40 half-periods.
    do_load(4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
    count_busy(nb);
    chk("max busy_len", nb, 6);
    total = 0;
    for (int k = 1; k <= 40; k++) begin
      wait_toggle(400, t);
      expi = (k == 1 || k == 40) ? 251 : 250;
      chk($sformatf("max interval%0d", k), t, expi);
      total += t;
    end
    chk("max total", total, 10002);

    // Rejected load while 12500 Hz runs.
    do_load(4'd1, 4'd2, 4'd5, 4'd0, 1'b1);
    count_busy(nb);
    chk("rej busy_len", nb, 6);
    wait_toggle(2100, t);
    chk("rej first", t, 2000);
    wait_toggle(2100, t);
    chk("rej interval_a", t, 2000);
    do_load(4'd3, 4'hA, 4'd3, 4'd3, 1'b0);
    chk("rej err", int'(err), 1);
    chk("rej busy", int'(busy), 0);
    chk("rej rangedisp", int'(rangedisp), 1);
    chk("rej active", int'(active), 1);
    wait_toggle(2100, t);
    chk("rej interval_b", t + 1, 2000);
    chk("rej busy_later", int'(busy), 0);
    wait_toggle(2100, t);
    chk("rej interval_c", t, 2000);
    chk("rej err_held", int'(err), 1);
    do_load(4'd5, 4'd0, 4'd0, 4'd0, 1'b1);
    chk("rej err_cleared", int'(err), 0);
    count_busy(nb);
    chk("rej reload busy_len", nb, 6);
    wait_toggle(550, t);
    chk("rej reload first", t, 500);

    // Load during the 3rd busy cycle is ignored.
    do_load(4'd4, 4'd3, 4'd2, 4'd1, 1'b1);
    @(posedge sysclk); #1;
    @(posedge sysclk); #1;
    chk("ign busy3", int'(busy), 1);
    @(negedge sysclk);
    freq3 = 4'd1; freq2 = 4'd1; freq1 = 4'd1; freq0 = 4'd1; range = 1'b0;
    load = 1'b1;
    @(posedge sysclk); #1;
    load = 1'b0;
    count_busy(nb);
    chk("ign busy_len", nb + 3, 6);
    chk("ign rangedisp", int'(rangedisp), 1);
    chk("ign active", int'(active), 1);
    chk("ign err", int'(err), 0);
    wait_toggle(650, t);
    chk("ign first", t, 579);

    // Reset on the 4th busy cycle.
    do_load(4'd1, 4'd2, 4'd5, 4'd0, 1'b1);
    repeat (3) begin
      @(posedge sysclk); #1;
    end
    rst = 1'b1;
    @(posedge sysclk); #1;
    rst = 1'b0;
    chk("rst sigout", int'(sigout), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst err", int'(err), 0);
    chk("rst active", int'(active), 0);
    chk("rst rangedisp", int'(rangedisp), 0);
    bad = 0;
    repeat (5000) begin
      @(posedge sysclk); #1;
      if (sigout !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("rst hold", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
